// File: rtl/multdiv_divider_pkg.sv
// Shared constants, state encoding and helpers for the multicycle signed divider.
package multdiv_divider_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Two's-complement magnitude; 0x80000000 maps to unsigned 2^31.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/multdiv_divider_div_step.sv
// One restoring shift-subtract iteration: shift {rem, quo} left, try subtracting the divisor.
module div_step
    import multdiv_divider_pkg::*;
(
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
    assign trial   = shifted - {1'b0, div_i};

    // A clear sign bit on the trial means the divisor fitted.
    assign rem_o = trial[WIDTH] ? shifted : trial;
    assign quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/multdiv_divider.sv
// Multicycle signed 32-bit divider: control FSM, sign handling and registers around div_step.
module multdiv_divider
    import multdiv_divider_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic             sign_q;
    logic             divzero_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;
    logic             rdy_q;

    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;

    div_step u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (div_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            sign_q    <= 1'b0;
            divzero_q <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            rdy_q <= 1'b0;
            if (ctrl_DIV) begin
                // A start in any state aborts whatever was in flight.
                quo_q     <= magnitude(data_operandA);
                div_q     <= magnitude(data_operandB);
                rem_q     <= '0;
                sign_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                divzero_q <= (data_operandB == '0);
                cnt_q     <= '0;
                state_q   <= RUN;
            end else begin
                case (state_q)
                    RUN: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(ITER - 1)) begin
                            state_q <= DONE;
                        end
                    end
                    DONE: begin
                        result_q <= divzero_q ? '0 : (sign_q ? -quo_q : quo_q);
                        exc_q    <= divzero_q;
                        rdy_q    <= 1'b1;
                        state_q  <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_divider.sv
// Directed bench for multdiv_divider: vector table plus abort, back-to-back and reset sequences.
module tb_multdiv_divider;

    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[15];

    multdiv_divider dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a start on the next rising edge, then scramble the operand pins.
    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h0000_0003;
    endtask

    // Edges from the start edge until RDY is seen; -1 if the budget runs out.
    task automatic wait_rdy(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic        seen;
        logic [31:0] held;

        vecs[0]  = '{32'd100,      32'd7,        32'd14,       1'b0};
        vecs[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0};
        vecs[2]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0};
        vecs[3]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       1'b0};
        vecs[4]  = '{32'd7,        32'd0,        32'd0,        1'b1};
        vecs[5]  = '{32'd6,        32'd3,        32'd2,        1'b0};
        vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};
        vecs[7]  = '{32'h80000000, 32'd1,        32'h80000000, 1'b0};
        vecs[8]  = '{32'hFFFFFFFF, 32'd2,        32'd0,        1'b0};
        vecs[9]  = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        1'b0};
        vecs[10] = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
        vecs[11] = '{32'h80000000, 32'h80000000, 32'd1,        1'b0};
        vecs[12] = '{32'd0,        32'd5,        32'd0,        1'b0};
        vecs[13] = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0};
        vecs[14] = '{32'hFFFFFFFF, 32'd0,        32'd0,        1'b1};

        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #2;
        check("reset_result", data_result, 32'd0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            do_start(vecs[i].a, vecs[i].b);
            wait_rdy(lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd33);
            check($sformatf("v%0d_result", i), data_result, vecs[i].res);
            check($sformatf("v%0d_exc", i), {31'd0, data_exception}, {31'd0, vecs[i].exc});
            @(posedge clock);
            #1;
            check($sformatf("v%0d_rdy_drop", i), {31'd0, data_resultRDY}, 32'd0);
            check($sformatf("v%0d_hold", i), data_result, vecs[i].res);
        end

        // Divide by zero, then a start in the very cycle RDY is high.
        do_start(32'd7, 32'd0);
        wait_rdy(lat);
        check("b2b_dz_exc", {31'd0, data_exception}, 32'd1);
        do_start(32'd6, 32'd3);
        check("b2b_hold_exc", {31'd0, data_exception}, 32'd1);
        check("b2b_hold_result", data_result, 32'd0);
        wait_rdy(lat);
        check("b2b_latency", 32'(lat), 32'd33);
        check("b2b_result", data_result, 32'd2);
        check("b2b_exc", {31'd0, data_exception}, 32'd0);

        // Abort: restart on cycle 10 of a running divide.
        do_start(32'd50, 32'd5);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clock);
            #1;
            seen = seen | data_resultRDY;
        end
        check("abort_no_early_rdy", {31'd0, seen}, 32'd0);
        do_start(32'd9, 32'd2);
        wait_rdy(lat);
        check("abort_latency", 32'(lat), 32'd33);
        check("abort_result", data_result, 32'd4);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            seen = seen | data_resultRDY;
        end
        check("abort_single_pulse", {31'd0, seen}, 32'd0);

        // Reset mid-run clears outputs at once and suppresses the pulse.
        held = data_result;
        check("pre_reset_result", held, 32'd4);
        do_start(32'd1000, 32'd10);
        repeat (14) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("midreset_result", data_result, 32'd0);
        check("midreset_exc", {31'd0, data_exception}, 32'd0);
        check("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            seen = seen | data_resultRDY;
        end
        check("postreset_no_rdy", {31'd0, seen}, 32'd0);
        do_start(32'd1000, 32'd10);
        wait_rdy(lat);
        check("postreset_latency", 32'(lat), 32'd33);
        check("postreset_result", data_result, 32'd100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multdiv_divider.md
Name: multdiv_divider

Overview:
- Multicycle signed 32-bit integer divider: the iterative counterpart to the ALU's single-cycle bitwise/arithmetic datapath.
- Sits beside the ALU in the execute stage. The pipeline issues a one-cycle ctrl_DIV pulse, stalls, and resumes when data_resultRDY pulses.
- Uses the restoring shift-subtract algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 32: operand, quotient and remainder width.
- ITER, 32: number of shift-subtract iterations; must equal WIDTH.

Ports:
- clock  input  1  sole clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- ctrl_DIV  input  1  start pulse; operands are sampled on the rising edge where it is high.
- data_operandA  input  WIDTH  dividend, two's complement.
- data_operandB  input  WIDTH  divisor, two's complement.
- data_result  output  WIDTH  quotient, truncated toward zero.
- data_exception  output  1  divide-by-zero flag, valid while data_resultRDY=1.
- data_resultRDY  output  1  one-cycle completion pulse.

Behaviour:
- Reset values:
  - state=IDLE, counter=0.
  - data_result=0, data_exception=0, data_resultRDY=0.
  - Internal quotient, remainder and divisor registers=0.
- States:
  - IDLE: waits for ctrl_DIV.
  - RUN: 32 iterations.
  - DONE: one cycle; outputs are registered.
  - DONE always returns to IDLE.
- Start (edge E0, ctrl_DIV=1), in any state:
  - Latch |A| into the quotient register and |B| into the divisor register; clear the 33-bit remainder.
  - Record sign = A[31] XOR B[31] and divzero = (B==0).
  - counter=0, state=RUN.
- RUN, each edge:
  - Shift {remainder, quotient} left by 1.
  - trial = remainder - {0, divisor}. If trial is non-negative, remainder=trial and quotient LSB=1; else quotient LSB=0.
  - counter++. When counter reaches ITER-1 on this edge, next state=DONE.
- DONE (edge E33):
  - data_result = sign ? -quotient : quotient. If divzero, data_result=0.
  - data_exception=divzero, data_resultRDY=1.
  - state=IDLE.
- Latency and holding:
  - data_resultRDY is high in exactly the cycle following edge E33.
  - data_result and data_exception are held until the next start.
  - data_resultRDY deasserts on the next edge.
- Divide by zero: same 33-cycle latency as a normal divide; result 0, exception 1.
- Overflow: 0x80000000 / 0xFFFFFFFF returns 0x80000000 (wraps) with exception 0. Magnitude of 0x80000000 is treated as unsigned 2^31.
- Remainder is internal only and is not exported.
- ctrl_DIV asserted during RUN or DONE aborts the current divide and restarts with the new operands. No RDY pulse is produced for the aborted operation.
- ctrl_DIV asserted in the same cycle data_resultRDY=1 starts a new divide normally. Outputs keep their old values until the new DONE.
- Operands are sampled only at the start edge; later changes on data_operandA/B are ignored.
- Reset asserted mid-RUN returns to IDLE asynchronously and clears all outputs. No RDY pulse follows.

Decomposition:
- Shared package:
  - WIDTH and ITER constants.
  - State encoding IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Counter width = clog2(ITER).
- One sub-module, div_step (combinational):
  - Inputs: 33-bit remainder, quotient, divisor.
  - Outputs: next remainder and next quotient for one restoring iteration.
  - Keeps the top-level to control, sign handling and registers.

Test Plan:
- A=100, B=7, pulse ctrl_DIV → RDY high exactly 33 cycles after the start edge; result=14, exception=0.
- A=-100 (0xFFFFFF9C), B=7 → result=0xFFFFFFF2 (-14). A=100, B=-7 → 0xFFFFFFF2. A=-100, B=-7 → 14.
- A=7, B=0 → after 33 cycles, RDY=1, exception=1, result=0. Then A=6, B=3 → exception=0, result=2.
- A=0x80000000, B=0xFFFFFFFF → result=0x80000000, exception=0. A=0x80000000, B=1 → 0x80000000.
- Start A=50, B=5; at cycle 10 re-pulse ctrl_DIV with A=9, B=2 → single RDY pulse 33 cycles after the second start; result=4; no pulse for the first divide.
- Start A=1000, B=10; assert reset at cycle 15 → all outputs 0 immediately and no RDY afterwards. A fresh start after reset release gives result=100 after 33 cycles.
